// File: rtl/apb_mem_pkg.sv
// Shared types and helpers for the parametrised APB memory slave.
// The optional byte-strobe write path is enabled by the APB_STRB_EN macro.
package apb_mem_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_t;

    localparam int WCNT_W     = 4;
    localparam int MAX_DATA_W = 1024;

    // Expands one enable bit per byte lane into a full bit mask; callers slice the low DATA_W bits.
    function automatic logic [MAX_DATA_W-1:0] strb_mask(input logic [MAX_DATA_W/8-1:0] strb);
        logic [MAX_DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_DATA_W/8; i++) begin
            m[i*8 +: 8] = {8{strb[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/apb_mem_array.sv
// DEPTH x DATA_W flop storage: async clear, bit-masked write port, combinational read port.
// Index decode is done by comparison so addresses beyond DEPTH never index past the array.
module apb_mem_array
    import apb_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int AW     = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] wr_mask,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_addr == AW'(i)) begin
                    mem[i] <= (mem[i] & ~wr_mask) | (wr_data & wr_mask);
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr == AW'(i)) begin
                rd_data = mem[i];
            end
        end
    end

endmodule

// File: rtl/apb_mem_slave_p.sv
// APB3 register-file slave with per-direction wait states and PSLVERR on out-of-range words.
// Define APB_STRB_EN to add the PSTRB port and byte-lane write enables.
module apb_mem_slave_p
    import apb_mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 64,
    parameter int WAIT_RD = 0,
    parameter int WAIT_WR = 0
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [ADDR_W-1:0]   PADDR,
    input  logic [DATA_W-1:0]   PWDATA,
`ifdef APB_STRB_EN
    input  logic [DATA_W/8-1:0] PSTRB,
`endif
    output logic [DATA_W-1:0]   PRDATA,
    output logic                PREADY,
    output logic                PSLVERR
);

    localparam int                AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [WCNT_W-1:0] WAIT_RD_C = WCNT_W'(WAIT_RD);
    localparam logic [WCNT_W-1:0] WAIT_WR_C = WCNT_W'(WAIT_WR);
    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);

    apb_state_t        state_q, state_d;
    logic [WCNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic              capture;
    logic              ready;
    logic              err_addr;
    logic              we;
    logic [DATA_W-1:0] wr_mask;
    logic [DATA_W-1:0] rd_data;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Address and direction only matter while in ACCESS, so they are captured without reset.
    always_ff @(posedge PCLK) begin
        if (capture) begin
            addr_q <= PADDR;
            wr_q   <= PWRITE;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        ready   = 1'b0;
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    capture = 1'b1;
                    cnt_d   = PWRITE ? WAIT_WR_C : WAIT_RD_C;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (PENABLE) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        ready   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign err_addr = ({1'b0, addr_q} >= DEPTH_C);
    assign we       = ready & wr_q & ~err_addr;

`ifdef APB_STRB_EN
    logic [MAX_DATA_W/8-1:0] strb_full;
    logic [MAX_DATA_W-1:0]   mask_full;

    always_comb begin
        strb_full               = '0;
        strb_full[DATA_W/8-1:0] = PSTRB;
        mask_full               = strb_mask(strb_full);
        wr_mask                 = mask_full[DATA_W-1:0];
    end
`else
    assign wr_mask = '1;
`endif

    apb_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_array (
        .clk     (PCLK),
        .rst     (PRESET),
        .we      (we),
        .wr_addr (addr_q[AW-1:0]),
        .wr_data (PWDATA),
        .wr_mask (wr_mask),
        .rd_addr (addr_q[AW-1:0]),
        .rd_data (rd_data)
    );

    assign PREADY  = ready;
    assign PSLVERR = ready & err_addr;
    assign PRDATA  = (ready && !wr_q && !err_addr) ? rd_data : '0;

endmodule

// File: tb/tb_apb_mem_slave_p.sv
// Scoreboard bench for apb_mem_slave_p: one zero-wait and one wait-state instance on a shared bus.
// Define APB_STRB_EN to also exercise the byte-strobe write path.
module tb_apb_mem_slave_p;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
`ifdef APB_STRB_EN
    logic [3:0]  pstrb;
`endif
    logic [31:0] prdata0, prdata1;
    logic [1:0]  pready, pslverr;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] mem_m [2][64];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb_mem_slave_p #(.DATA_W(32), .ADDR_W(8), .DEPTH(64), .WAIT_RD(0), .WAIT_WR(0)) dut0 (
        .PCLK (clk), .PRESET (rst), .PSEL (psel[0]), .PENABLE (penable), .PWRITE (pwrite),
        .PADDR (paddr), .PWDATA (pwdata),
`ifdef APB_STRB_EN
        .PSTRB (pstrb),
`endif
        .PRDATA (prdata0), .PREADY (pready[0]), .PSLVERR (pslverr[0])
    );

    apb_mem_slave_p #(.DATA_W(32), .ADDR_W(8), .DEPTH(64), .WAIT_RD(2), .WAIT_WR(3)) dut1 (
        .PCLK (clk), .PRESET (rst), .PSEL (psel[1]), .PENABLE (penable), .PWRITE (pwrite),
        .PADDR (paddr), .PWDATA (pwdata),
`ifdef APB_STRB_EN
        .PSTRB (pstrb),
`endif
        .PRDATA (prdata1), .PREADY (pready[1]), .PSLVERR (pslverr[1])
    );

    task automatic model_clear();
        for (int d = 0; d < 2; d++)
            for (int a = 0; a < 64; a++)
                mem_m[d][a] = '0;
    endtask

    task automatic push(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Drives setup and access phases; returns after the PREADY cycle without releasing the bus.
    task automatic xfer(input int d, input bit wr, input logic [7:0] a,
                        input logic [31:0] data, input logic [3:0] st);
        exp_t e;
        int   w;
        int   n;
        @(posedge clk); #1;
        psel       = 2'b00;
        psel[d]    = 1'b1;
        penable    = 1'b0;
        pwrite     = wr;
        paddr      = a;
        pwdata     = data;
`ifdef APB_STRB_EN
        pstrb      = st;
`endif
        w      = (d == 0) ? 0 : (wr ? 3 : 2);
        e.cyc  = cyc + 1 + w;
        e.err  = (a >= 8'd64);
        e.data = (!wr && a < 8'd64) ? mem_m[d][a[5:0]] : 32'h0;
        push(d, e);
        if (wr && a < 8'd64) begin
            for (int i = 0; i < 4; i++) begin
`ifdef APB_STRB_EN
                if (st[i]) mem_m[d][a[5:0]][i*8 +: 8] = data[i*8 +: 8];
`else
                mem_m[d][a[5:0]][i*8 +: 8] = data[i*8 +: 8];
`endif
            end
        end
        @(posedge clk); #1;
        penable = 1'b1;
        n = 0;
        @(negedge clk);
        while (!pready[d] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (pready[d] !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL xfer_timeout dut%0d addr=%0d: PREADY got %b, required 1", d, a, pready[d]);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        psel    = 2'b00;
        penable = 1'b0;
        paddr   = 8'($urandom);
    endtask

    task automatic check(input int d, input logic rdy, input logic err, input logic [31:0] rd);
        exp_t e;
        bit   empty;
        vectors++;
        if (rdy === 1'b1) begin
            empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
                miscompares++;
                $display("FAIL unexpected_pready dut%0d cyc=%0d: PREADY got 1, required 0", d, cyc);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                if (cyc != e.cyc || err !== e.err || rd !== e.data) begin
                    miscompares++;
                    $display("FAIL completion dut%0d: cyc/err/data got %0d/%b/%h, required %0d/%b/%h",
                             d, cyc, err, rd, e.cyc, e.err, e.data);
                end
            end
        end else if (rdy !== 1'b0 || err !== 1'b0 || rd !== 32'h0) begin
            miscompares++;
            $display("FAIL idle_outputs dut%0d cyc=%0d: ready/err/data got %b/%b/%h, required 0/0/0",
                     d, cyc, rdy, err, rd);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check(0, pready[0], pslverr[0], prdata0);
                check(1, pready[1], pslverr[1], prdata1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        exp_t e;
        rst     = 1'b1;
        psel    = 2'b00;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
`ifdef APB_STRB_EN
        pstrb   = 4'hF;
`endif
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Enable with no preceding setup must be ignored by both slaves.
        #1 penable = 1'b1;
        repeat (2) @(posedge clk);
        #1 penable = 1'b0;

        // Reset asserted in the completion cycle of a wait-state write.
        xfer(1, 1'b1, 8'd7, 32'hCAFEF00D, 4'hF);
        idle();
        @(posedge clk); #1;
        psel    = 2'b10;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 8'd7;
        pwdata  = 32'h0BADF00D;
        e.cyc   = cyc + 4;
        e.err   = 1'b0;
        e.data  = 32'h0;
        push(1, e);
        @(posedge clk); #1 penable = 1'b1;
        n = 0;
        @(negedge clk);
        while (!pready[1] && n < 40) begin
            @(negedge clk);
            n++;
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (pready[1] !== 1'b0 || pslverr[1] !== 1'b0 || prdata1 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: ready/err/data got %b/%b/%h, required 0/0/0",
                     pready[1], pslverr[1], prdata1);
        end
        psel    = 2'b00;
        penable = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        model_clear();
        xfer(1, 1'b0, 8'd7, 32'h0, 4'hF);
        idle();

        // Zero-wait write/read, back-to-back.
        xfer(0, 1'b1, 8'd5, 32'hDEADBEEF, 4'hF);
        xfer(0, 1'b0, 8'd5, 32'h0, 4'hF);
        idle();

        // Wait-state write/read.
        xfer(1, 1'b1, 8'd9, 32'h13579BDF, 4'hF);
        xfer(1, 1'b0, 8'd9, 32'h0, 4'hF);
        idle();

        // Out-of-range accesses on both instances.
        xfer(0, 1'b1, 8'd64, 32'h12345678, 4'hF);
        xfer(0, 1'b0, 8'd64, 32'h0, 4'hF);
        xfer(0, 1'b0, 8'd63, 32'h0, 4'hF);
        xfer(1, 1'b1, 8'd255, 32'h12345678, 4'hF);
        xfer(1, 1'b0, 8'd255, 32'h0, 4'hF);
        idle();

        // Back-to-back write then read of address 0.
        xfer(0, 1'b1, 8'd0, 32'hA5A5A5A5, 4'hF);
        xfer(0, 1'b0, 8'd0, 32'h0, 4'hF);
        idle();

`ifdef APB_STRB_EN
        xfer(0, 1'b1, 8'd3, 32'h11223344, 4'hF);
        xfer(0, 1'b1, 8'd3, 32'hAABBCCDD, 4'b0101);
        xfer(0, 1'b0, 8'd3, 32'h0, 4'hF);
        xfer(0, 1'b1, 8'd3, 32'hFFFFFFFF, 4'b0000);
        xfer(0, 1'b0, 8'd3, 32'h0, 4'hF);
        idle();
`endif

        // Abort: PSEL dropped during the wait phase of a write.
        xfer(1, 1'b1, 8'd12, 32'h55AA55AA, 4'hF);
        idle();
        @(posedge clk); #1;
        psel    = 2'b10;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 8'd12;
        pwdata  = 32'hFEEDFACE;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1;
        psel    = 2'b00;
        penable = 1'b0;
        repeat (6) @(posedge clk);
        xfer(1, 1'b0, 8'd12, 32'h0, 4'hF);
        idle();

        // Randomised traffic across both instances.
        for (int k = 0; k < 120; k++) begin
            xfer(int'($urandom_range(0, 1)), 1'($urandom), 8'($urandom_range(0, 69)),
                 $urandom, 4'($urandom));
            if ($urandom_range(0, 2) == 0) idle();
        end
        idle();
        repeat (5) @(posedge clk);

        vectors++;
        if (q0.size() != 0 || q1.size() != 0) begin
            miscompares++;
            $display("FAIL pending_expectations: got %0d/%0d left, required 0/0", q0.size(), q1.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
